// File: rtl/mipi_hs_lp_tx_ctrl.sv
// DSI PHY-side HS/LP sequencer for clock and data lanes.
// Runs LP11->LP01->LP00->HS-zero entry and HS-trail->LP11 exit.
module mipi_hs_lp_tx_ctrl #(
    parameter int LANES       = 4,
    parameter int T_CLK_LP01  = 8,
    parameter int T_CLK_LP00  = 8,
    parameter int T_CLK_ZERO  = 30,
    parameter int T_CLK_PRE   = 2,
    parameter int T_DAT_LP01  = 8,
    parameter int T_DAT_LP00  = 8,
    parameter int T_DAT_ZERO  = 16,
    parameter int T_DAT_TRAIL = 8,
    parameter int T_CLK_POST  = 14,
    parameter int T_CLK_TRAIL = 8,
    parameter bit CLK_CONT    = 1'b0
) (
    input  logic               I_lcd_clk,
    input  logic               I_rst_n,
    input  logic               I_init_done,
    input  logic [1:0]         I_init_lp_data,
    input  logic               I_hs_req,
    input  logic [LANES*8-1:0] I_hs_data,
    output logic               O_hs_rdy,
    output logic               O_busy,
    output logic               O_hs_clk_en,
    output logic               O_hs_data_en,
    output logic [LANES*8-1:0] O_hs_data,
    output logic [LANES*2-1:0] O_lp_data,
    output logic [1:0]         O_lp_clk
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_CLK_LP01  = 4'd1;
    localparam logic [3:0] S_CLK_LP00  = 4'd2;
    localparam logic [3:0] S_CLK_ZERO  = 4'd3;
    localparam logic [3:0] S_CLK_PRE   = 4'd4;
    localparam logic [3:0] S_DAT_LP01  = 4'd5;
    localparam logic [3:0] S_DAT_LP00  = 4'd6;
    localparam logic [3:0] S_DAT_ZERO  = 4'd7;
    localparam logic [3:0] S_HS_DATA   = 4'd8;
    localparam logic [3:0] S_DAT_TRAIL = 4'd9;
    localparam logic [3:0] S_CLK_POST  = 4'd10;
    localparam logic [3:0] S_CLK_TRAIL = 4'd11;

    localparam bit T_OK =
        (T_CLK_LP01  >= 1) && (T_CLK_LP01  <= 255) &&
        (T_CLK_LP00  >= 1) && (T_CLK_LP00  <= 255) &&
        (T_CLK_ZERO  >= 1) && (T_CLK_ZERO  <= 255) &&
        (T_CLK_PRE   >= 1) && (T_CLK_PRE   <= 255) &&
        (T_DAT_LP01  >= 1) && (T_DAT_LP01  <= 255) &&
        (T_DAT_LP00  >= 1) && (T_DAT_LP00  <= 255) &&
        (T_DAT_ZERO  >= 1) && (T_DAT_ZERO  <= 255) &&
        (T_DAT_TRAIL >= 1) && (T_DAT_TRAIL <= 255) &&
        (T_CLK_POST  >= 1) && (T_CLK_POST  <= 255) &&
        (T_CLK_TRAIL >= 1) && (T_CLK_TRAIL <= 255);

    if (LANES < 1 || LANES > 4) begin : g_bad_lanes
        $error("mipi_hs_lp_tx_ctrl: LANES must be 1..4");
    end
    if (!T_OK) begin : g_bad_timing
        $error("mipi_hs_lp_tx_ctrl: T_* must be 1..255");
    end

    logic [3:0]         state;
    logic [3:0]         state_nxt;
    logic [7:0]         cnt;
    logic               done;
    logic               clk_on;
    logic               clk_on_nxt;
    logic [1:0]         lp_clk_q;
    logic [1:0]         lp_clk_nxt;
    logic               hs_clk_en_q;
    logic               hs_clk_en_nxt;
    logic [LANES*2-1:0] lp_data_q;
    logic [LANES*2-1:0] lp_data_nxt;
    logic               hs_data_en_q;
    logic               hs_data_en_nxt;
    logic [LANES*8-1:0] hs_q;
    logic [LANES*8-1:0] hs_nxt;
    logic               busy_q;

    // Counter preload is T-1 so each timed state lasts exactly T cycles.
    function automatic logic [7:0] tload(input logic [3:0] s);
        case (s)
            S_CLK_LP01:  return 8'(T_CLK_LP01 - 1);
            S_CLK_LP00:  return 8'(T_CLK_LP00 - 1);
            S_CLK_ZERO:  return 8'(T_CLK_ZERO - 1);
            S_CLK_PRE:   return 8'(T_CLK_PRE - 1);
            S_DAT_LP01:  return 8'(T_DAT_LP01 - 1);
            S_DAT_LP00:  return 8'(T_DAT_LP00 - 1);
            S_DAT_ZERO:  return 8'(T_DAT_ZERO - 1);
            S_DAT_TRAIL: return 8'(T_DAT_TRAIL - 1);
            S_CLK_POST:  return 8'(T_CLK_POST - 1);
            S_CLK_TRAIL: return 8'(T_CLK_TRAIL - 1);
            default:     return 8'd0;
        endcase
    endfunction

    assign done = (cnt == 8'd0);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:
                if (I_hs_req)
                    state_nxt = clk_on ? S_DAT_LP01 : S_CLK_LP01;
            S_CLK_LP01:  if (done) state_nxt = S_CLK_LP00;
            S_CLK_LP00:  if (done) state_nxt = S_CLK_ZERO;
            S_CLK_ZERO:  if (done) state_nxt = S_CLK_PRE;
            S_CLK_PRE:   if (done) state_nxt = S_DAT_LP01;
            S_DAT_LP01:  if (done) state_nxt = S_DAT_LP00;
            S_DAT_LP00:  if (done) state_nxt = S_DAT_ZERO;
            S_DAT_ZERO:  if (done) state_nxt = S_HS_DATA;
            S_HS_DATA:   if (!I_hs_req) state_nxt = S_DAT_TRAIL;
            S_DAT_TRAIL:
                if (done)
                    state_nxt = CLK_CONT ? S_IDLE : S_CLK_POST;
            S_CLK_POST:  if (done) state_nxt = S_CLK_TRAIL;
            S_CLK_TRAIL: if (done) state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
        if (!I_init_done)
            state_nxt = S_IDLE;
    end

    always_comb begin
        clk_on_nxt = clk_on;
        if (state_nxt == S_CLK_ZERO)
            clk_on_nxt = 1'b1;
        if (state == S_CLK_TRAIL && state_nxt == S_IDLE)
            clk_on_nxt = 1'b0;
        if (!I_init_done)
            clk_on_nxt = 1'b0;
    end

    // Lane outputs are decoded from the next state so they are
    // registered yet visible in the very cycle a state is entered.
    always_comb begin
        lp_clk_nxt = 2'b11;
        if (state_nxt == S_CLK_LP01)
            lp_clk_nxt = 2'b01;
        else if (state_nxt >= S_CLK_LP00 && state_nxt <= S_CLK_TRAIL)
            lp_clk_nxt = 2'b00;
        else if (state_nxt == S_IDLE && clk_on_nxt)
            lp_clk_nxt = 2'b00;

        hs_clk_en_nxt =
            (state_nxt >= S_CLK_ZERO && state_nxt <= S_CLK_TRAIL) ||
            (state_nxt == S_IDLE && clk_on_nxt);

        lp_data_nxt = {LANES{2'b11}};
        if (state_nxt == S_DAT_LP01)
            lp_data_nxt = {LANES{2'b01}};
        else if (state_nxt >= S_DAT_LP00 && state_nxt <= S_DAT_TRAIL)
            lp_data_nxt = '0;

        hs_data_en_nxt =
            (state_nxt >= S_DAT_ZERO && state_nxt <= S_DAT_TRAIL);
    end

    always_comb begin
        hs_nxt = '0;
        if (state_nxt == S_HS_DATA) begin
            hs_nxt = (state == S_HS_DATA && I_hs_req) ? I_hs_data : hs_q;
        end else if (state_nxt == S_DAT_TRAIL) begin
            hs_nxt = hs_q;
            if (state == S_HS_DATA)
                for (int n = 0; n < LANES; n++)
                    hs_nxt[8*n +: 8] = {8{~hs_q[8*n+7]}};
        end
    end

    always_ff @(posedge I_lcd_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state        <= S_IDLE;
            cnt          <= 8'd0;
            clk_on       <= 1'b0;
            lp_clk_q     <= 2'b11;
            hs_clk_en_q  <= 1'b0;
            lp_data_q    <= {LANES{2'b11}};
            hs_data_en_q <= 1'b0;
            hs_q         <= '0;
            busy_q       <= 1'b0;
        end else begin
            state        <= state_nxt;
            clk_on       <= clk_on_nxt;
            lp_clk_q     <= lp_clk_nxt;
            hs_clk_en_q  <= hs_clk_en_nxt;
            lp_data_q    <= lp_data_nxt;
            hs_data_en_q <= hs_data_en_nxt;
            hs_q         <= hs_nxt;
            busy_q       <= (state_nxt != S_IDLE);
            if (state_nxt != state)
                cnt <= tload(state_nxt);
            else if (!done)
                cnt <= cnt - 8'd1;
        end
    end

    assign O_hs_rdy     = (state == S_HS_DATA);
    assign O_busy       = busy_q;
    assign O_hs_clk_en  = hs_clk_en_q;
    assign O_hs_data_en = hs_data_en_q;
    assign O_hs_data    = hs_q;
    assign O_lp_clk     = lp_clk_q;

    always_comb begin
        O_lp_data = lp_data_q;
        if (!I_init_done)
            O_lp_data[1:0] = I_init_lp_data;
    end

endmodule

// File: tb/tb_mipi_hs_lp_tx_ctrl.sv
// Bench for mipi_hs_lp_tx_ctrl: default gated-clock 4-lane instance
// and a 2-lane continuous-clock instance.
module tb_mipi_hs_lp_tx_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_init_done, a_req, a_rdy, a_busy, a_hce, a_hde;
    logic [1:0]  a_init_lp, a_lpc;
    logic [31:0] a_data, a_hs;
    logic [7:0]  a_lp;

    logic        b_init_done, b_req, b_rdy, b_busy, b_hce, b_hde;
    logic [1:0]  b_init_lp, b_lpc;
    logic [15:0] b_data, b_hs;
    logic [3:0]  b_lp;

    mipi_hs_lp_tx_ctrl u0 (
        .I_lcd_clk(clk), .I_rst_n(rst_n),
        .I_init_done(a_init_done), .I_init_lp_data(a_init_lp),
        .I_hs_req(a_req), .I_hs_data(a_data),
        .O_hs_rdy(a_rdy), .O_busy(a_busy),
        .O_hs_clk_en(a_hce), .O_hs_data_en(a_hde),
        .O_hs_data(a_hs), .O_lp_data(a_lp), .O_lp_clk(a_lpc)
    );

    mipi_hs_lp_tx_ctrl #(.LANES(2), .CLK_CONT(1'b1)) u1 (
        .I_lcd_clk(clk), .I_rst_n(rst_n),
        .I_init_done(b_init_done), .I_init_lp_data(b_init_lp),
        .I_hs_req(b_req), .I_hs_data(b_data),
        .O_hs_rdy(b_rdy), .O_busy(b_busy),
        .O_hs_clk_en(b_hce), .O_hs_data_en(b_hde),
        .O_hs_data(b_hs), .O_lp_data(b_lp), .O_lp_clk(b_lpc)
    );

    typedef struct {
        int          cyc;
        logic [1:0]  lpc;
        logic        hce;
        logic [7:0]  lp;
        logic        hde;
        logic        rdy;
        logic        busy;
        logic        chk_hs;
        logic [31:0] hs;
    } vec_t;

    typedef struct {
        int          cyc;
        logic [31:0] val;
    } sb_t;

    vec_t        tbl[$];
    sb_t         sb[$];
    logic [31:0] bytes [4];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int idx, nacc, n, m;
    bit dropped;

    function automatic vec_t v(input int c, input logic [1:0] lpc,
                               input logic hce, input logic [7:0] lp,
                               input logic hde, input logic rdy,
                               input logic busy, input logic ch,
                               input logic [31:0] hs);
        vec_t r;
        r.cyc = c; r.lpc = lpc; r.hce = hce; r.lp = lp;
        r.hde = hde; r.rdy = rdy; r.busy = busy;
        r.chk_hs = ch; r.hs = hs;
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d act=%h exp=%h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_vec(input vec_t t);
        chk($sformatf("vec_c%0d", t.cyc),
            {a_lpc, a_hce, a_lp, a_hde, a_rdy, a_busy},
            {t.lpc, t.hce, t.lp, t.hde, t.rdy, t.busy});
        if (t.chk_hs)
            chk($sformatf("vec_hs_c%0d", t.cyc), a_hs, t.hs);
    endtask

    task automatic chk_a_reset(input string name);
        chk(name, {a_lpc, a_hce, a_lp, a_hde, a_rdy, a_busy, a_hs},
            {2'b11, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 32'h0});
    endtask

    task automatic wait_a_rdy(input int lim, output int cnt);
        cnt = 0;
        while (!a_rdy && cnt < lim) begin tick; cnt++; end
    endtask

    task automatic wait_a_idle(input int lim, output int cnt);
        cnt = 0;
        while (a_busy && cnt < lim) begin tick; cnt++; end
    endtask

    task automatic wait_b_rdy(input int lim, output int cnt);
        cnt = 0;
        while (!b_rdy && cnt < lim) begin tick; cnt++; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        a_init_done = 1'b1; a_init_lp = 2'b00; a_req = 1'b0; a_data = '0;
        b_init_done = 1'b1; b_init_lp = 2'b00; b_req = 1'b0; b_data = '0;

        bytes[0] = 32'hF0408111;
        bytes[1] = 32'hF1418212;
        bytes[2] = 32'hF2428313;
        bytes[3] = 32'hF3438414;

        // Expected entry/exit timeline for the default instance.
        tbl.push_back(v(0,   2'b11, 0, 8'hFF, 0, 0, 0, 1, 32'h0));
        tbl.push_back(v(1,   2'b01, 0, 8'hFF, 0, 0, 1, 1, 32'h0));
        tbl.push_back(v(8,   2'b01, 0, 8'hFF, 0, 0, 1, 1, 32'h0));
        tbl.push_back(v(9,   2'b00, 0, 8'hFF, 0, 0, 1, 1, 32'h0));
        tbl.push_back(v(16,  2'b00, 0, 8'hFF, 0, 0, 1, 1, 32'h0));
        tbl.push_back(v(17,  2'b00, 1, 8'hFF, 0, 0, 1, 1, 32'h0));
        tbl.push_back(v(48,  2'b00, 1, 8'hFF, 0, 0, 1, 1, 32'h0));
        tbl.push_back(v(49,  2'b00, 1, 8'h55, 0, 0, 1, 1, 32'h0));
        tbl.push_back(v(56,  2'b00, 1, 8'h55, 0, 0, 1, 1, 32'h0));
        tbl.push_back(v(57,  2'b00, 1, 8'h00, 0, 0, 1, 1, 32'h0));
        tbl.push_back(v(64,  2'b00, 1, 8'h00, 0, 0, 1, 1, 32'h0));
        tbl.push_back(v(65,  2'b00, 1, 8'h00, 1, 0, 1, 1, 32'h0));
        tbl.push_back(v(80,  2'b00, 1, 8'h00, 1, 0, 1, 1, 32'h0));
        tbl.push_back(v(81,  2'b00, 1, 8'h00, 1, 1, 1, 1, 32'h0));
        tbl.push_back(v(85,  2'b00, 1, 8'h00, 1, 1, 1, 0, 32'h0));
        tbl.push_back(v(86,  2'b00, 1, 8'h00, 1, 0, 1, 0, 32'h0));
        tbl.push_back(v(93,  2'b00, 1, 8'h00, 1, 0, 1, 0, 32'h0));
        tbl.push_back(v(94,  2'b00, 1, 8'hFF, 0, 0, 1, 1, 32'h0));
        tbl.push_back(v(107, 2'b00, 1, 8'hFF, 0, 0, 1, 1, 32'h0));
        tbl.push_back(v(115, 2'b00, 1, 8'hFF, 0, 0, 1, 1, 32'h0));
        tbl.push_back(v(116, 2'b11, 0, 8'hFF, 0, 0, 0, 1, 32'h0));
        tbl.push_back(v(120, 2'b11, 0, 8'hFF, 0, 0, 0, 1, 32'h0));

        #12;
        chk_a_reset("rst_a");
        chk("rst_b", {b_lpc, b_hce, b_lp, b_hde, b_rdy, b_busy, b_hs},
            {2'b11, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 16'h0});
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        tick;

        cyc = 0; idx = 0; nacc = 0; dropped = 0;
        for (int c = 0; c <= 120; c++) begin
            if (idx < tbl.size() && tbl[idx].cyc == cyc) begin
                chk_vec(tbl[idx]);
                idx++;
            end
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                sb_t s;
                s = sb.pop_front();
                chk("sb_hs", a_hs, s.val);
            end
            a_req = (nacc < 4);
            if (a_rdy && a_req) begin
                a_data = bytes[nacc];
                sb.push_back('{cyc + 1, bytes[nacc]});
                nacc++;
            end else if (a_rdy && !a_req && !dropped) begin
                dropped = 1;
                for (int k = 1; k <= 8; k++)
                    sb.push_back('{cyc + k, 32'h00FF00FF});
            end
            tick;
        end
        chk("tbl_done", idx, tbl.size());
        chk("sb_empty", sb.size(), 0);
        chk("accepts", nacc, 4);

        // Requests are ignored while init is pending; lane0 LP is bypassed.
        a_init_done = 1'b0; a_init_lp = 2'b10; a_req = 1'b1;
        #1;
        chk("init_lp_comb", a_lp[1:0], 2'b10);
        repeat (3) tick;
        chk("ign_req", {a_busy, a_lpc, a_hce, a_lp},
            {1'b0, 2'b11, 1'b0, 8'hFE});

        a_init_done = 1'b1;
        wait_a_rdy(100, n);
        chk("ab_lat", n, 81);
        a_data = 32'h5A5A5A5A;
        tick;
        chk("ab_byte", a_hs, 32'h5A5A5A5A);
        a_init_done = 1'b0; a_req = 1'b0;
        tick;
        chk("abort", {a_lpc, a_hce, a_lp, a_hde, a_rdy, a_busy, a_hs},
            {2'b11, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0, 32'h0});
        a_init_done = 1'b1;
        tick;
        tick;

        // One-cycle request pulse: entry, empty HS_DATA, trail, exit.
        a_req = 1'b1;
        tick;
        a_req = 1'b0;
        wait_a_rdy(100, m);
        chk("p_lat", 1 + m, 81);
        tick;
        chk("p_trail", {a_hde, a_lp, a_hs}, {1'b1, 8'h00, 32'hFFFFFFFF});
        repeat (8) tick;
        chk("p_post", {a_hde, a_lp, a_hce, a_hs},
            {1'b0, 8'hFF, 1'b1, 32'h0});
        wait_a_idle(50, n);
        chk("p_exit_lat", n, 22);
        chk("p_idle", {a_lpc, a_hce}, {2'b11, 1'b0});
        tick;

        // Async reset in the middle of clock-lane HS-zero.
        a_req = 1'b1;
        repeat (40) tick;
        chk("pre_rst", {a_busy, a_hce}, {1'b1, 1'b1});
        #2;
        rst_n = 1'b0;
        #1;
        chk_a_reset("async_rst");
        a_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick;

        // Two-lane continuous-clock instance.
        b_req = 1'b1;
        wait_b_rdy(100, n);
        chk("b_lat", n, 81);
        b_data = 16'hC305;
        tick;
        chk("b_byte0", b_hs, 16'hC305);
        b_data = 16'h1286;
        tick;
        chk("b_byte1", b_hs, 16'h1286);
        b_req = 1'b0;
        tick;
        chk("b_trail", {b_hde, b_lp, b_hs}, {1'b1, 4'h0, 16'hFF00});
        repeat (7) tick;
        chk("b_trail_end", {b_hde, b_hs}, {1'b1, 16'hFF00});
        tick;
        chk("b_idle_cont", {b_busy, b_hce, b_lpc, b_lp, b_hde, b_hs},
            {1'b0, 1'b1, 2'b00, 4'hF, 1'b0, 16'h0});
        repeat (5) tick;
        chk("b_clk_held", {b_hce, b_lpc}, {1'b1, 2'b00});

        b_req = 1'b1;
        tick;
        chk("b2_lp01", {b_lp, b_lpc, b_hce}, {4'b0101, 2'b00, 1'b1});
        wait_b_rdy(60, n);
        chk("b2_rdy_lat", n, 32);
        b_req = 1'b0;
        tick;
        chk("b2_trail", {b_hde, b_hs}, {1'b1, 16'hFFFF});
        repeat (8) tick;
        chk("b2_idle", {b_busy, b_hce, b_lpc, b_lp},
            {1'b0, 1'b1, 2'b00, 4'hF});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
